// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: N producer channels in, one registered consumer port out.
// The master side drives inputs and the consumer ready; the slave side is the multiplexer.
interface mux_rr_reg_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_src;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_rr_reg.sv
// N-channel registered multiplexer with valid/ready handshakes; picks a channel either by
// direct select or by round-robin arbitration and holds the word under back-pressure.
module mux_rr_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input logic         clk,
    input logic         rst,
    mux_rr_reg_if.slave bus
);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load_en;
    logic             dir_vld;
    logic             rr_vld;
    logic [SEL_W-1:0] rr_gnt;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gnt_data;
    logic [N-1:0]     in_ready;

    assign load_en = !out_valid_q || bus.out_ready;
    // Out-of-range select (non-power-of-two N) never grants.
    assign dir_vld = (32'(bus.sel) < N) && bus.in_valid[bus.sel];

    // First valid channel at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx    = 0;
        rr_vld = 1'b0;
        rr_gnt = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(N)) idx = idx - int'(N);
            if (!rr_vld && bus.in_valid[SEL_W'(idx)]) begin
                rr_vld = 1'b1;
                rr_gnt = SEL_W'(idx);
            end
        end
    end

    assign gnt     = bus.mode ? rr_gnt : bus.sel;
    assign gnt_vld = bus.mode ? rr_vld : dir_vld;

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data    = bus.in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load_en && gnt_vld && !rst;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                out_data_d  = gnt_data;
                out_src_d   = gnt;
                out_valid_d = 1'b1;
                if (bus.mode) begin
                    rr_ptr_d = (gnt == SEL_W'(N - 1)) ? '0 : gnt + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised successor to the datapath 8:1 selector: an N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshakes.
- Two modes: direct select and round-robin arbitration.
- Sits between multiple producers (writeback sources, forwarding paths, memory/ALU result queues) and a single consumer stage.
- Registers the selected word with a one-cycle latency and back-pressure support.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- N, 8, number of input channels (2..16).
- SEL_W, $clog2(N), width of the select and source-index fields (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i holds a word.
- in_ready  output  N  channel i word is consumed this cycle (combinational).
- mode  input  1  0 = direct select via sel; 1 = round-robin arbitration.
- sel  input  SEL_W  channel index used in mode 0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready is all zero while rst=1.
  - Any in-flight word is discarded.
- load_en = !out_valid || out_ready. The output register may load when it is empty or being drained in the same cycle. Full throughput is 1 word/cycle.
- Grant, mode 0:
  - gnt_vld = (sel < N) && in_valid[sel]; gnt = sel.
  - sel >= N (non-power-of-two N) gives no grant.
  - rr_ptr is held.
- Grant, mode 1:
  - Search i = rr_ptr, rr_ptr+1, ... wrapping modulo N.
  - gnt is the first i with in_valid[i]=1; gnt_vld = |in_valid.
- Handshake:
  - in_ready[i] = load_en && gnt_vld && (gnt == i). At most one bit is set per cycle.
  - A transfer occurs on channel i when in_valid[i] && in_ready[i].
- On a rising edge with load_en && gnt_vld:
  - out_data <= in_data[gnt]; out_src <= gnt; out_valid <= 1.
  - In mode 1 only: rr_ptr <= (gnt == N-1) ? 0 : gnt+1.
- On a rising edge with load_en && !gnt_vld: out_valid <= 0. out_data and out_src hold their last values.
- On a rising edge with !load_en (out_valid=1, out_ready=0): out_data, out_src and out_valid hold (stall). No in_ready is asserted.
- Latency: a word accepted at edge k appears on out_data after edge k and is valid from cycle k+1.
- Simultaneous drain and load: the old word is consumed and the new word is registered on the same edge, with no bubble.
- Mode or sel changes take effect on the next combinational grant. A registered word is never altered.
- rr_ptr wraps from N-1 to 0. It is not reset by mode switches.
- Producers must keep in_data and in_valid stable until a transfer. The block does not check this.
- No combinational path from out_ready to out_data. A path from out_ready to in_ready is permitted.

Test Plan:
- Reset mid-stall: out_valid=1 with out_data=16'hBEEF and out_ready=0, pulse rst between clock edges -> out_valid, out_data and out_src drop to 0 immediately; in_ready=0 while rst=1.
- Mode 0 direct select: N=8, in_data[3]=16'h1234, in_valid=8'b0000_1000, sel=3, out_ready=1 -> in_ready=8'b0000_1000; next cycle out_data=16'h1234, out_src=3, out_valid=1. With sel=2 instead -> in_ready=0 and out_valid falls to 0.
- Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,...,7,0,1 with rr_ptr wrapping 7->0.
- Back-pressure: mode=1, in_valid=8'b0010_0100, out_ready=0 after the first load -> out_src=2 and out_data held for 5 stall cycles with in_ready=0; on release, channel 5 is loaded next with no bubble and out_valid stays 1.
- Round-robin skip: rr_ptr=6 with only in_valid[1] and in_valid[4] set -> grant 1 (wraps past 6,7,0); rr_ptr becomes 2; next grant is 4.
- Non-power-of-two: N=5, SEL_W=3, mode 0, sel=6, in_valid=5'b11111 -> no grant, in_ready=0, out_valid=0. Then mode=1 with rr_ptr=4 -> grant 4, and rr_ptr wraps to 0.
